// File: rtl/vcm_focus_search_pkg.sv
// Shared types and VCM command word layout for the contrast autofocus sequencer.
package vcm_focus_search_pkg;

  localparam int POS_W        = 10;
  localparam int SUM_W        = 32;
  localparam int VCM_W        = 16;
  localparam int SLEW_W       = 4;
  localparam int VCM_POS_LSB  = 4;
  localparam int VCM_SLEW_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_MOVE    = 4'd1,
    ST_HOLD    = 4'd2,
    ST_SETTLE  = 4'd3,
    ST_MEASURE = 4'd4,
    ST_STEP    = 4'd5,
    ST_DONE    = 4'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_COARSE = 2'd0,
    PH_FINE   = 2'd1,
    PH_FINAL  = 2'd2,
    PH_MANUAL = 2'd3
  } phase_e;

  function automatic logic [VCM_W-1:0] vcm_word(input logic [POS_W-1:0]  pos,
                                                input logic [SLEW_W-1:0] slew);
    logic [VCM_W-1:0] w;
    w = '0;
    w[VCM_POS_LSB +: POS_W]   = pos;
    w[VCM_SLEW_LSB +: SLEW_W] = slew;
    return w;
  endfunction

endpackage

// File: rtl/vcm_focus_search_trigger_pulse.sv
// Write trigger for the VCM I2C stage: TR held high for TR_HOLD cycles per load,
// with done_o marking the last high cycle.
module vcm_trigger_pulse #(
  parameter int unsigned TR_HOLD = 256
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic tr_o,
  output logic done_o
);

  localparam int CNT_W = $clog2(TR_HOLD + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tr_q, tr_d;

  always_comb begin
    cnt_d = cnt_q;
    tr_d  = tr_q;
    if (load_i) begin
      tr_d  = 1'b1;
      cnt_d = CNT_W'(TR_HOLD - 1);
    end else if (tr_q) begin
      if (cnt_q == '0) begin
        tr_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      tr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tr_q  <= tr_d;
    end
  end

  assign tr_o   = tr_q;
  assign done_o = tr_q && (cnt_q == '0) && !load_i;

endmodule

// File: rtl/vcm_focus_search.sv
// Contrast-driven autofocus: coarse sweep, fine sweep around the coarse peak,
// then park at the best fine position. Also passes manual lens codes through.
module vcm_focus_search
  import vcm_focus_search_pkg::*;
#(
  parameter int unsigned       POS_MIN       = 0,
  parameter int unsigned       POS_MAX       = 1023,
  parameter int unsigned       COARSE_STEP   = 64,
  parameter int unsigned       FINE_STEP     = 8,
  parameter int unsigned       SETTLE_FRAMES = 2,
  parameter int unsigned       TR_HOLD       = 256,
  parameter logic [SLEW_W-1:0] SLEW          = 4'h0
) (
  input  logic               CLK_50,
  input  logic               RESET,
  input  logic               AF_START,
  input  logic               MANUAL_EN,
  input  logic [POS_W-1:0]   MANUAL_POS,
  input  logic               VS,
  input  logic               FOCUS_VALID,
  input  logic [SUM_W-1:0]   FOCUS_SUM,
  output logic [VCM_W-1:0]   VCM_DATA,
  output logic               TR_OUT,
  output logic               AF_BUSY,
  output logic               AF_DONE,
  output logic [POS_W-1:0]   BEST_POS,
  output logic [SUM_W-1:0]   BEST_SUM,
  output logic [3:0]         ST
);

  localparam int FR_W = $clog2(SETTLE_FRAMES + 2);
  localparam logic [POS_W-1:0] P_MIN    = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX    = POS_W'(POS_MAX);
  localparam logic [POS_W:0]   C_STEP11 = (POS_W+1)'(COARSE_STEP);
  localparam logic [POS_W:0]   F_STEP11 = (POS_W+1)'(FINE_STEP);

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] hi_q, hi_d;
  logic [POS_W-1:0] vcm_pos_q, vcm_pos_d;
  logic [POS_W-1:0] best_pos_q, best_pos_d;
  logic [SUM_W-1:0] best_sum_q, best_sum_d;
  logic             busy_q, busy_d;
  logic [FR_W-1:0]  frame_q, frame_d;
  logic             vs_q;

  logic             vs_rise;
  logic             tr_load, tr_done;
  logic [POS_W:0]   step11, next11, hi_wide;
  logic [POS_W+1:0] lo_wide;
  logic [POS_W-1:0] lo_clamp, hi_clamp;

  assign vs_rise = VS && !vs_q;

  // Fine window is computed wide so that the clamps see underflow/overflow.
  assign step11   = (phase_q == PH_COARSE) ? C_STEP11 : F_STEP11;
  assign next11   = {1'b0, pos_q} + step11;
  assign lo_wide  = {2'b00, best_pos_q} - (POS_W+2)'(COARSE_STEP);
  assign hi_wide  = {1'b0, best_pos_q} + C_STEP11;
  assign lo_clamp = ($signed(lo_wide) < $signed((POS_W+2)'(POS_MIN))) ? P_MIN : lo_wide[POS_W-1:0];
  assign hi_clamp = (hi_wide > {1'b0, P_MAX}) ? P_MAX : hi_wide[POS_W-1:0];

  vcm_trigger_pulse #(
    .TR_HOLD (TR_HOLD)
  ) u_trig (
    .clk_i   (CLK_50),
    .reset_i (RESET),
    .load_i  (tr_load),
    .tr_o    (TR_OUT),
    .done_o  (tr_done)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pos_d      = pos_q;
    hi_d       = hi_q;
    vcm_pos_d  = vcm_pos_q;
    best_pos_d = best_pos_q;
    best_sum_d = best_sum_q;
    busy_d     = busy_q;
    frame_d    = frame_q;
    tr_load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (AF_START && !MANUAL_EN) begin
          pos_d      = P_MIN;
          hi_d       = P_MAX;
          best_sum_d = '0;
          phase_d    = PH_COARSE;
          busy_d     = 1'b1;
          state_d    = ST_MOVE;
        end else if (MANUAL_EN && (MANUAL_POS != vcm_pos_q)) begin
          pos_d   = MANUAL_POS;
          phase_d = PH_MANUAL;
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        vcm_pos_d = pos_q;
        tr_load   = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (tr_done) begin
          if (phase_q == PH_MANUAL) begin
            state_d = ST_IDLE;
          end else if (phase_q == PH_FINAL) begin
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            frame_d = FR_W'(SETTLE_FRAMES);
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (frame_q == '0) begin
          state_d = ST_MEASURE;
        end else if (vs_rise) begin
          frame_d = frame_q - FR_W'(1);
        end
      end
      ST_MEASURE: begin
        if (FOCUS_VALID) begin
          if (FOCUS_SUM > best_sum_q) begin
            best_sum_d = FOCUS_SUM;
            best_pos_d = pos_q;
          end
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        state_d = ST_MOVE;
        if (next11 <= {1'b0, hi_q}) begin
          pos_d = next11[POS_W-1:0];
        end else if (phase_q == PH_COARSE) begin
          hi_d    = hi_clamp;
          pos_d   = lo_clamp;
          phase_d = PH_FINE;
        end else begin
          pos_d   = best_pos_q;
          phase_d = PH_FINAL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_COARSE;
      pos_q      <= '0;
      hi_q       <= '0;
      vcm_pos_q  <= P_MIN;
      best_pos_q <= P_MIN;
      best_sum_q <= '0;
      busy_q     <= 1'b0;
      frame_q    <= '0;
      vs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      hi_q       <= hi_d;
      vcm_pos_q  <= vcm_pos_d;
      best_pos_q <= best_pos_d;
      best_sum_q <= best_sum_d;
      busy_q     <= busy_d;
      frame_q    <= frame_d;
      vs_q       <= VS;
    end
  end

  assign VCM_DATA = vcm_word(vcm_pos_q, SLEW);
  assign AF_BUSY  = busy_q;
  assign AF_DONE  = (state_q == ST_DONE);
  assign BEST_POS = best_pos_q;
  assign BEST_SUM = best_sum_q;
  assign ST       = state_q;

endmodule

// File: tb/tb_vcm_focus_search.sv
// Directed bench for vcm_focus_search with a free-running camera model that
// answers every lens move with frames and a sharpness score.
module tb_vcm_focus_search;

  logic        CLK_50      = 1'b0;
  logic        RESET       = 1'b1;
  logic        AF_START    = 1'b0;
  logic        MANUAL_EN   = 1'b0;
  logic [9:0]  MANUAL_POS  = '0;
  logic        VS          = 1'b0;
  logic        FOCUS_VALID = 1'b0;
  logic [31:0] FOCUS_SUM   = '0;
  logic [15:0] VCM_DATA;
  logic        TR_OUT;
  logic        AF_BUSY;
  logic        AF_DONE;
  logic [9:0]  BEST_POS;
  logic [31:0] BEST_SUM;
  logic [3:0]  ST;

  int errors = 0;
  int checks = 0;

  // camera / write monitor state
  int   model_mode  = 0;
  int   fcnt        = 0;
  int   edges_since = 0;
  logic tr_prev     = 1'b0;
  int   falls       = 0;
  int   cyc         = 0;
  int   last_fall   = -1;
  int   min_gap     = 1000000;
  int   maxpos      = 0;
  int   cur_pos     = 0;
  int   wpos[$];

  vcm_focus_search dut (
    .CLK_50      (CLK_50),
    .RESET       (RESET),
    .AF_START    (AF_START),
    .MANUAL_EN   (MANUAL_EN),
    .MANUAL_POS  (MANUAL_POS),
    .VS          (VS),
    .FOCUS_VALID (FOCUS_VALID),
    .FOCUS_SUM   (FOCUS_SUM),
    .VCM_DATA    (VCM_DATA),
    .TR_OUT      (TR_OUT),
    .AF_BUSY     (AF_BUSY),
    .AF_DONE     (AF_DONE),
    .BEST_POS    (BEST_POS),
    .BEST_SUM    (BEST_SUM),
    .ST          (ST)
  );

  always #5 CLK_50 = ~CLK_50;

  function automatic int model(input int mode, input int pos);
    int c, base, d;
    c    = (mode == 0) ? 300 : 1020;
    base = (mode == 0) ? 100000 : 200000;
    d    = (pos > c) ? pos - c : c - pos;
    return base - 100 * d;
  endfunction

  // Frames of 16 cycles: VS high for 2, FOCUS_VALID at cycle 8. Until the lens
  // has seen two VS edges since its last trigger edge the score is junk, so any
  // sample taken during HOLD/SETTLE would corrupt BEST_SUM.
  always @(negedge CLK_50) begin
    cyc++;
    if (tr_prev === 1'b1 && TR_OUT === 1'b0) begin
      falls++;
      if (last_fall >= 0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
      last_fall   = cyc;
      edges_since = 0;
    end
    if (tr_prev === 1'b0 && TR_OUT === 1'b1) begin
      cur_pos = int'(VCM_DATA[13:4]);
      wpos.push_back(cur_pos);
      if (cur_pos > maxpos) maxpos = cur_pos;
      edges_since = 0;
    end
    tr_prev = TR_OUT;
    fcnt = (fcnt + 1) % 16;
    if (fcnt == 0) edges_since++;
    VS          = (fcnt < 2);
    FOCUS_VALID = (fcnt == 8);
    FOCUS_SUM   = (edges_since >= 2) ? 32'(model(model_mode, cur_pos)) : 32'hFFFF_FFFF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qpos(input int i);
    return (i < wpos.size()) ? wpos[i] : -1;
  endfunction

  task automatic wait_writes(input int n, input int limit);
    int i;
    i = 0;
    while (wpos.size() < n && i < limit) begin
      @(negedge CLK_50);
      i++;
    end
    chk("write_wait", 32'(wpos.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (AF_DONE !== 1'b1 && i < limit) begin
      @(negedge CLK_50);
      i++;
    end
    chk("done_seen", 32'(AF_DONE), 32'd1);
  endtask

  task automatic clear_log();
    falls     = 0;
    wpos.delete();
    last_fall = -1;
    min_gap   = 1000000;
    maxpos    = 0;
  endtask

  task automatic pulse_start();
    AF_START = 1'b1;
    @(negedge CLK_50);
    AF_START = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_vcm"},      32'(VCM_DATA), 32'h0000);
    chk({pfx, "_tr"},       32'(TR_OUT),   32'd0);
    chk({pfx, "_busy"},     32'(AF_BUSY),  32'd0);
    chk({pfx, "_done"},     32'(AF_DONE),  32'd0);
    chk({pfx, "_best_pos"}, 32'(BEST_POS), 32'd0);
    chk({pfx, "_best_sum"}, BEST_SUM,      32'd0);
    chk({pfx, "_st"},       32'(ST),       32'd0);
  endtask

  initial begin
    // reset and idle
    repeat (3) @(negedge CLK_50);
    RESET = 1'b0;
    @(negedge CLK_50);
    chk_reset_vals("rst");
    clear_log();
    repeat (100) @(negedge CLK_50);
    chk("idle_falls", 32'(falls), 32'd0);
    chk("idle_vcm",   32'(VCM_DATA), 32'h0000);
    chk("idle_tr",    32'(TR_OUT), 32'd0);

    // full search, peak at 300; a second AF_START mid-search must be ignored
    model_mode = 0;
    clear_log();
    pulse_start();
    @(negedge CLK_50);
    chk("a_busy", 32'(AF_BUSY), 32'd1);
    wait_writes(20, 20000);
    pulse_start();
    wait_done(40000);
    chk("a_busy_at_done", 32'(AF_BUSY),  32'd0);
    chk("a_best_pos",     32'(BEST_POS), 32'd296);
    chk("a_best_sum",     BEST_SUM,      32'd99600);
    chk("a_vcm_final",    32'(VCM_DATA), 32'h1280);
    @(negedge CLK_50);
    chk("a_done_pulse",   32'(AF_DONE),  32'd0);
    chk("a_st_idle",      32'(ST),       32'd0);
    @(negedge CLK_50);
    chk("a_falls",        32'(falls),       32'd34);
    chk("a_writes",       32'(wpos.size()), 32'd34);
    chk("a_last_coarse",  32'(qpos(15)),    32'd960);
    chk("a_first_fine",   32'(qpos(16)),    32'd256);
    chk("a_last_fine",    32'(qpos(32)),    32'd384);
    chk("a_final_write",  32'(qpos(33)),    32'd296);
    chk("a_fall_spacing", 32'(min_gap >= 257), 32'd1);

    // peak near the top code: fine window clamps to 896..1023
    model_mode = 1;
    clear_log();
    pulse_start();
    wait_done(40000);
    chk("b_best_pos",    32'(BEST_POS), 32'd1016);
    chk("b_best_sum",    BEST_SUM,      32'd199600);
    chk("b_vcm_final",   32'(VCM_DATA), 32'h3F80);
    repeat (2) @(negedge CLK_50);
    chk("b_falls",       32'(falls),       32'd33);
    chk("b_writes",      32'(wpos.size()), 32'd33);
    chk("b_first_fine",  32'(qpos(16)),    32'd896);
    chk("b_last_fine",   32'(qpos(31)),    32'd1016);
    chk("b_final_write", 32'(qpos(32)),    32'd1016);
    chk("b_max_pos",     32'(maxpos),      32'd1016);
    chk("b_fall_spacing", 32'(min_gap >= 257), 32'd1);

    // reset in the middle of the fine sweep while the trigger is high
    model_mode = 0;
    clear_log();
    pulse_start();
    wait_writes(20, 20000);
    @(negedge CLK_50);
    chk("c_tr_high", 32'(TR_OUT), 32'd1);
    RESET = 1'b1;
    @(negedge CLK_50);
    RESET = 1'b0;
    chk_reset_vals("c_abort");
    @(negedge CLK_50);
    clear_log();
    pulse_start();
    wait_writes(2, 2000);
    chk("c_restart_pos0", 32'(qpos(0)), 32'd0);
    chk("c_restart_pos1", 32'(qpos(1)), 32'd64);
    chk("c_restart_busy", 32'(AF_BUSY), 32'd1);
    RESET = 1'b1;
    @(negedge CLK_50);
    RESET = 1'b0;
    @(negedge CLK_50);

    // manual drive: exactly one write, AF_START has no effect in manual mode
    clear_log();
    MANUAL_POS = 10'h155;
    MANUAL_EN  = 1'b1;
    repeat (400) @(negedge CLK_50);
    chk("m_vcm",    32'(VCM_DATA),    32'h1550);
    chk("m_falls",  32'(falls),       32'd1);
    chk("m_writes", 32'(wpos.size()), 32'd1);
    chk("m_busy",   32'(AF_BUSY),     32'd0);
    pulse_start();
    repeat (500) @(negedge CLK_50);
    chk("m_falls_hold", 32'(falls),   32'd1);
    chk("m_busy_hold",  32'(AF_BUSY), 32'd0);
    chk("m_st_idle",    32'(ST),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
